// File: rtl/sqrt_fp_iter_pkg.sv
// Package pa_SqrtIter: shared types and helpers for the iterative FP square root.
//   dual_rail_t   : packed {data_0, data_1} rail pair (00 = spacer)
//   state_e       : controller states
//   sqrt_flags_t  : {invalid, inexact}
//   to_dual_rail  : encode one bit onto a rail pair
//   canon_nan     : canonical quiet NaN pattern for a given EW/FW
package pa_SqrtIter;

  typedef struct packed {
    logic data_0;
    logic data_1;
  } dual_rail_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    ROUND,
    DONE
  } state_e;

  typedef struct packed {
    logic invalid;
    logic inexact;
  } sqrt_flags_t;

  function automatic dual_rail_t to_dual_rail(input logic b);
    dual_rail_t r;
    r.data_0 = ~b;
    r.data_1 = b;
    return r;
  endfunction

  // Sign 0, exponent all ones, fraction MSB only; callers truncate to EW+FW+1.
  function automatic logic [63:0] canon_nan(input int unsigned ew, input int unsigned fw);
    logic [63:0] r;
    r = ((64'd1 << ew) - 64'd1) << fw;
    r = r | (64'd1 << (fw - 1));
    return r;
  endfunction

endpackage

// File: rtl/sqrt_fp_iter_step.sv
// sqrt_iter_step: one combinational iteration of the restoring square root.
//   i_rem  : partial remainder
//   i_root : root bits produced so far
//   i_pair : next two radicand bits (MSB first)
//   o_rem  : remainder after this iteration
//   o_bit  : root bit produced by this iteration
module sqrt_iter_step #(
  parameter int unsigned N = 25
) (
  input  logic [N:0]   i_rem,
  input  logic [N-1:0] i_root,
  input  logic [1:0]   i_pair,
  output logic [N:0]   o_rem,
  output logic         o_bit
);

  logic [N+2:0] w_a;
  logic [N+2:0] w_b;
  logic [N+2:0] w_diff;
  logic         w_ge;

  assign w_a    = {i_rem, i_pair};
  assign w_b    = {1'b0, i_root, 2'b01};
  assign w_diff = w_a - w_b;
  assign w_ge   = (w_a >= w_b);

  // The remainder never exceeds twice the root, so the top two bits of both
  // the trial and the restored value are always zero.
  assign o_bit = w_ge;
  assign o_rem = w_ge ? w_diff[N:0] : w_a[N:0];

  logic w_unused;
  assign w_unused = ^{w_diff[N+2:N+1], w_a[N+2:N+1]};

endmodule

// File: rtl/sqrt_fp_iter.sv
// sqrt_fp_iter: clocked IEEE-754 square root, one root bit per cycle.
// Optional macro SQRT_DUAL_RAIL_OUT_EN adds out_dr_o (dual-rail copy of the result).
//   clk_i, rst_ni              : clock, synchronous active-low reset
//   in_valid_i / in_ready_o    : operand handshake, in_operand_i = {sign, exp, frac}
//   out_valid_o / out_ready_i  : result handshake, out_result_o = {sign, exp, frac}
//   out_flags_o                : {invalid, inexact}
//   busy_o                     : controller not idle
//   out_dr_o                   : (macro only) dual-rail result, spacer when not valid
module sqrt_fp_iter
  import pa_SqrtIter::*;
#(
  parameter int unsigned EW = 8,
  parameter int unsigned FW = 23
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [EW+FW:0]     in_operand_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [EW+FW:0]     out_result_o,
  output logic [1:0]         out_flags_o,
  output logic               busy_o
`ifdef SQRT_DUAL_RAIL_OUT_EN
  ,
  output dual_rail_t [EW+FW:0] out_dr_o
`endif
);

  localparam int unsigned W    = EW + FW + 1;
  localparam int unsigned BIAS = 2**(EW-1) - 1;
  localparam int unsigned N    = FW + 2;
  localparam int unsigned CW   = $clog2(N + 1);
  localparam logic [W-1:0] QNAN = W'(canon_nan(EW, FW));

  state_e          r_state, w_next;
  logic [CW-1:0]   r_cnt;
  logic [2*N-1:0]  r_rad;
  logic [N:0]      r_rem;
  logic [N-1:0]    r_root;
  logic [EW:0]     r_exp;
  logic [W-1:0]    r_result;
  sqrt_flags_t     r_flags;

  // Operand decode
  logic            w_sign, w_exp_zero, w_exp_ones, w_frac_zero, w_special;
  logic [EW-1:0]   w_exp;
  logic [FW-1:0]   w_frac;
  logic [N-1:0]    w_m, w_m_sh;
  logic [EW:0]     w_exp_sum, w_res_exp;

  assign w_sign      = in_operand_i[W-1];
  assign w_exp       = in_operand_i[W-2:FW];
  assign w_frac      = in_operand_i[FW-1:0];
  assign w_exp_zero  = (w_exp == '0);
  assign w_exp_ones  = (w_exp == '1);
  assign w_frac_zero = (w_frac == '0);
  assign w_special   = w_exp_zero | w_exp_ones | w_sign;

  // Even biased exponent means an odd unbiased one: pre-scale the radicand by 2.
  assign w_m       = {2'b01, w_frac};
  assign w_m_sh    = w_exp[0] ? w_m : (w_m << 1);
  assign w_exp_sum = {1'b0, w_exp} + (EW+1)'(BIAS);
  assign w_res_exp = w_exp_sum >> 1;

  logic [W-1:0]    w_spec_res;
  sqrt_flags_t     w_spec_flags;

  always_comb begin
    w_spec_res   = QNAN;
    w_spec_flags = '0;
    if (w_exp_ones && !w_frac_zero) begin
      w_spec_res = QNAN;
    end else if (w_exp_zero) begin
      w_spec_res = {w_sign, {(W-1){1'b0}}};
    end else if (w_sign) begin
      w_spec_flags.invalid = 1'b1;
    end else begin
      w_spec_res = in_operand_i;
    end
  end

  // Iteration
  logic [N:0] w_rem_nxt;
  logic       w_bit;

  sqrt_iter_step #(.N(N)) u_step (
    .i_rem  (r_rem),
    .i_root (r_root),
    .i_pair (r_rad[2*N-1 -: 2]),
    .o_rem  (w_rem_nxt),
    .o_bit  (w_bit)
  );

  // Rounding: the fraction carry flows straight into the exponent.
  logic [FW+1:0] w_sum;
  logic [EW:0]   w_fin_exp;
  logic [W-1:0]  w_round_res;
  sqrt_flags_t   w_round_flags;

  assign w_sum       = {1'b0, r_root[N-1:1]} + (FW+2)'(r_root[0]);
  assign w_fin_exp   = r_exp + (EW+1)'(w_sum[FW+1]);
  assign w_round_res = {1'b0, w_fin_exp[EW-1:0], w_sum[FW-1:0]};
  always_comb begin
    w_round_flags         = '0;
    w_round_flags.inexact = r_root[0] | (|r_rem);
  end

  logic w_unused;
  assign w_unused = ^{w_sum[FW], w_fin_exp[EW]};

  logic          w_load, w_release;
  logic [W-1:0]  w_load_val;
  sqrt_flags_t   w_load_flags;

  assign w_load       = ((r_state == IDLE) && in_valid_i && w_special) || (r_state == ROUND);
  assign w_release    = (r_state == DONE) && out_ready_i;
  assign w_load_val   = (r_state == ROUND) ? w_round_res : w_spec_res;
  assign w_load_flags = (r_state == ROUND) ? w_round_flags : w_spec_flags;

  // Controller
  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid_i) w_next = w_special ? DONE : CALC;
      CALC:    if (r_cnt == CW'(N - 1)) w_next = ROUND;
      ROUND:   w_next = DONE;
      DONE:    if (out_ready_i) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_cnt  <= '0;
      r_rad  <= '0;
      r_rem  <= '0;
      r_root <= '0;
      r_exp  <= '0;
    end else begin
      case (r_state)
        IDLE: if (in_valid_i) begin
          r_cnt  <= '0;
          r_rem  <= '0;
          r_root <= '0;
          r_rad  <= {w_m_sh, {N{1'b0}}};
          r_exp  <= w_res_exp;
        end
        CALC: begin
          r_rem  <= w_rem_nxt;
          r_root <= {r_root[N-2:0], w_bit};
          r_rad  <= r_rad << 2;
          r_cnt  <= r_cnt + 1'b1;
        end
        ROUND:   r_cnt <= '0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_result <= '0;
      r_flags  <= '0;
    end else if (w_load) begin
      r_result <= w_load_val;
      r_flags  <= w_load_flags;
    end
  end

  assign in_ready_o   = (r_state == IDLE);
  assign out_valid_o  = (r_state == DONE);
  assign busy_o       = (r_state != IDLE);
  assign out_result_o = r_result;
  assign out_flags_o  = r_flags;

`ifdef SQRT_DUAL_RAIL_OUT_EN
  dual_rail_t [W-1:0] w_dr_load;
  dual_rail_t [W-1:0] r_dr;

  always_comb begin
    w_dr_load = '0;
    for (int unsigned i = 0; i < W; i++) w_dr_load[i] = to_dual_rail(w_load_val[i]);
  end

  // Loaded together with the result and cleared on release, so the rails sit
  // at spacer whenever out_valid_o is low, including throughout reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni)        r_dr <= '0;
    else if (w_load)    r_dr <= w_dr_load;
    else if (w_release) r_dr <= '0;
  end

  assign out_dr_o = r_dr;
`endif

endmodule
